div16by8_td: RTL and testbench
==============================

# div16by8_td

Registered sequential divider: the inverse of the team's registered radix-4 Booth multiplier. It accepts a 2*WIDTH-bit dividend and a WIDTH-bit divisor through a valid/ready handshake. It runs one restoring-division step per cycle and presents a 2*WIDTH-bit quotient, a WIDTH-bit remainder and status flags through a second handshake. It sits beside the multiplier in the arithmetic datapath, so products can be divided back down, e.g. for rescaling and normalisation.

## Interface
- WIDTH, 8, divisor/remainder width; dividend/quotient width is 2*WIDTH.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  2*WIDTH  dividend.
- divisor  in  WIDTH  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  2*WIDTH  quotient.
- remainder  out  WIDTH  remainder.
- dbz  out  1  divide-by-zero flag.
- ovf  out  1  signed overflow flag.

## Operation
- Operand format is set by the Configuration macro: two's complement or unsigned.
- FSM states:
  - **IDLE**
    - in_ready=1.
    - When in_valid is high, register the operands into dividend_reg/divisor_reg, clear the step counter and go to LOAD.
  - **LOAD**
    - Take the magnitudes of the registered operands (signed mode).
    - Record sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
    - Go to CALC.
  - **CALC**
    - 2*WIDTH restoring iterations on a (WIDTH+1)-bit partial remainder. Each iteration:
      - shift in the next dividend bit, MSB first;
      - compare/subtract the divisor magnitude;
      - shift the quotient bit in.
    - When counter = 2*WIDTH-1, go to FIX.
  - **FIX**
    - Apply the sign fix-up: negate the quotient if sign_q; negate the remainder if sign_r.
    - Apply the special cases below.
    - Load the output registers and go to DONE.
  - **DONE**
    - out_valid=1; outputs are held stable.
    - When out_ready is high, go to IDLE.
- Rounding: the quotient truncates toward zero. The remainder takes the sign of the dividend and satisfies |remainder| < |divisor|.
- Divisor = 0:
  - dbz=1, quotient = all ones, remainder = dividend[WIDTH-1:0].
  - Latency is unchanged.
- Signed, dividend = -2^(2W-1) and divisor = -1:
  - ovf=1, quotient = 2^(2W-1) bit pattern (0x8000 at WIDTH=8), remainder = 0.
- ovf is always 0 in unsigned mode, and whenever dbz=1.

## Timing
- Reset:
  - state = IDLE, in_ready = 0 on the reset cycle and 1 afterwards.
  - out_valid = 0; quotient, remainder, dbz, ovf = 0; internal registers = 0.
- Accept occurs on the edge where in_valid && in_ready.
- Latency: out_valid rises exactly 2*WIDTH+3 cycles after the accept edge (19 at WIDTH=8): LOAD 1, CALC 2*WIDTH, FIX 1, plus the output register.
- in_ready is low outside IDLE; in_valid asserted while busy is ignored and not queued.
- out_valid stays high, with outputs frozen, until out_ready. Backpressure has no limit.
- in_ready rises the cycle after the out handshake; back-to-back throughput is one result per 2*WIDTH+4 cycles.
- out_ready while out_valid=0 has no effect.
- RST asserted in any state aborts the operation and takes the block to IDLE with reset values on the next edge; any partial result is discarded.

## Configuration
- DIV_SIGNED_EN defined:
  - operands and results are two's complement;
  - LOAD/FIX sign handling and the ovf case are present.
- Not defined:
  - operands are unsigned; the LOAD magnitude step and the FIX negation logic are compiled out;
  - ovf is tied to 0; state sequencing and latency are identical.

## Structure
- The shared package holds:
  - the state enum (IDLE, LOAD, CALC, FIX, DONE);
  - the counter width localparam $clog2(2*WIDTH);
  - a function returning the overflow-case dividend constant.
- Sub-module div_step is purely combinational: one restoring step that takes the partial remainder, the next dividend bit and the divisor, and returns the new partial remainder and the quotient bit. It is instantiated once and used iteratively.

## Test plan
- Unsigned: 1000 / 7 -> quotient 142, remainder 6, dbz=0, ovf=0; out_valid at cycle 19 after accept.
- Signed: -1000 / 7 -> quotient -142 (0xFF72), remainder -6 (0xFA); and 1000 / -7 -> quotient 0xFF72, remainder 6.
- Divide by zero: 0x1234 / 0 -> dbz=1, quotient 0xFFFF, remainder 0x34, ovf=0.
- Signed overflow: 0x8000 / 0xFF -> ovf=1, quotient 0x8000, remainder 0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 continuously.
  - Required: outputs stable, in_ready=0 throughout.
  - After the handshake, the next operand pair is accepted one cycle later.
- Reset mid-CALC: assert RST at step 5.
  - Required: the next cycle shows in_ready=0 and out_valid=0 with all outputs 0.
  - A fresh 255 / 16 then returns quotient 15, remainder 15.

Source files
------------

// File: rtl/div16by8_td_pkg.sv
// div16by8_td_pkg: shared definitions for the registered 16/8 divider.
//   - DIV_WIDTH   : default divisor/remainder width (dividend/quotient is 2x)
//   - CNT_W       : step counter width, $clog2(2*DIV_WIDTH)
//   - state_t     : controller states IDLE/LOAD/CALC/FIX/DONE
//   - ovf_dividend: the most negative 2W-bit dividend (the signed ovf case)
// Signed operation is selected by defining DIV_SIGNED_EN at compile time.
package div16by8_td_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(2*DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } state_t;

  // -2^(2w-1) as a bit pattern; also the quotient pattern reported on ovf.
  function automatic logic [31:0] ovf_dividend(input int w);
    return 32'h1 << (2*w - 1);
  endfunction

endpackage

// File: rtl/div16by8_td_div_step.sv
// div_step: one combinational restoring-division step.
//   pr     in  WIDTH+1  current partial remainder (always < divisor)
//   din    in  1        next dividend bit, MSB first
//   dvs    in  WIDTH    divisor magnitude
//   pr_nxt out WIDTH+1  partial remainder after the step
//   qbit   out 1        quotient bit produced by the step
// Used by div16by8_td (DIV_SIGNED_EN selects signed mode there; this step is
// always unsigned).
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   pr,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   pr_nxt,
  output logic             qbit
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sh     = {pr[WIDTH-1:0], din};
    diff   = sh - {1'b0, dvs};
    // pr[WIDTH] is the bit shifted out; if set the shifted value exceeds any
    // divisor, so the subtract always succeeds and the low bits of diff are exact.
    qbit   = pr[WIDTH] | (sh >= {1'b0, dvs});
    pr_nxt = qbit ? diff : sh;
  end

endmodule

// File: rtl/div16by8_td.sv
// div16by8_td: registered sequential restoring divider, 2W-bit / W-bit.
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (dividend 2W, divisor W)
//   out_valid/out_ready result handshake (quotient 2W, remainder W)
//   dbz                 divisor was zero
//   ovf                 signed -2^(2W-1) / -1 overflow
// Sequence: IDLE -> LOAD -> CALC (2W steps) -> FIX -> DONE.
// Compile-time option: DIV_SIGNED_EN selects two's complement operands;
// undefined selects unsigned operands with ovf tied low.
module div16by8_td
  import div16by8_td_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               dbz,
  output logic               ovf
);

  localparam int DW = 2*WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] OVF_DVD = DW'(ovf_dividend(WIDTH));

  state_t state, state_nxt;

  logic            rdy_q;
  logic            accept;
  logic [DW-1:0]   dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [DW-1:0]   sh_q;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]  pr_q;
  logic [CW-1:0]   cnt;

  logic [WIDTH:0]  pr_nxt;
  logic            qbit;

  logic [DW-1:0]    dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [DW-1:0]    q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             ovf_c;

  // Registered so that in_ready stays low for the cycle following reset.
  assign in_ready  = rdy_q;
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && rdy_q && in_valid;

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr     (pr_q),
    .din    (sh_q[DW-1]),
    .dvs    (dvs_mag),
    .pr_nxt (pr_nxt),
    .qbit   (qbit)
  );

`ifdef DIV_SIGNED_EN
  logic sign_q, sign_r;

  always_comb begin
    dvd_mag_c = dividend_reg[DW-1]   ? -dividend_reg : dividend_reg;
    dvs_mag_c = divisor_reg[WIDTH-1] ? -divisor_reg  : divisor_reg;
    q_fix     = sign_q ? -sh_q : sh_q;
    r_fix     = sign_r ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
    ovf_c     = (dividend_reg == OVF_DVD) && (divisor_reg == '1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (state == LOAD) begin
      sign_q <= dividend_reg[DW-1] ^ divisor_reg[WIDTH-1];
      sign_r <= dividend_reg[DW-1];
    end
  end
`else
  always_comb begin
    dvd_mag_c = dividend_reg;
    dvs_mag_c = divisor_reg;
    q_fix     = sh_q;
    r_fix     = pr_q[WIDTH-1:0];
    ovf_c     = 1'b0;
  end
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    if (cnt == CW'(DW-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      sh_q         <= '0;
      dvs_mag      <= '0;
      pr_q         <= '0;
      cnt          <= '0;
      quotient     <= '0;
      remainder    <= '0;
      dbz          <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dividend_reg <= dividend;
          divisor_reg  <= divisor;
          cnt          <= '0;
        end
        LOAD: begin
          sh_q    <= dvd_mag_c;
          dvs_mag <= dvs_mag_c;
          pr_q    <= '0;
        end
        CALC: begin
          pr_q <= pr_nxt;
          sh_q <= {sh_q[DW-2:0], qbit};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          // Divide-by-zero wins over overflow so ovf is never set with dbz.
          if (divisor_reg == '0) begin
            quotient  <= '1;
            remainder <= dividend_reg[WIDTH-1:0];
            dbz       <= 1'b1;
            ovf       <= 1'b0;
          end else if (ovf_c) begin
            quotient  <= OVF_DVD;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16by8_td.sv
// tb_div16by8_td: self-checking bench for div16by8_td (unsigned by default,
// signed scenarios enabled when DIV_SIGNED_EN is defined).
module tb_div16by8_td;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready, out_valid, dbz, ovf;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int checks = 0;
  int errors = 0;

  localparam int LAT = 19;

  div16by8_td dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .dbz(dbz), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  // Reference: plain integer division with the special cases layered on top.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic dz, output logic of);
    int sa, sb;
    dz = 1'b0; of = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 8'd0) begin
      dz = 1'b1; q = 16'hFFFF; r = a[7:0];
      return;
    end
`ifdef DIV_SIGNED_EN
    if (sa == -32768 && sb == -1) begin
      of = 1'b1; q = 16'h8000; r = 8'h00;
      return;
    end
    q = 16'(sa / sb);
    r = 8'(sa % sb);
`else
    q = a / {8'd0, b};
    r = 8'(a % {8'd0, b});
`endif
  endfunction

  // Drives one operation from a negedge and returns the captured result and
  // the cycle index (accept cycle = 0) at which out_valid was first seen.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic dz, output logic of,
                        output int lat, output bit to);
    int n;
    q = '0; r = '0; dz = 1'b0; of = 1'b0; lat = 0; to = 1'b0; n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    if (in_ready !== 1'b1) begin to = 1'b1; return; end
    dividend = a; divisor = b; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge CLK); lat++; end
    if (out_valid !== 1'b1) begin to = 1'b1; return; end
    q = quotient; r = remainder; dz = dbz; of = ovf;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h56;
    repeat (2) @(negedge CLK);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, dbz, ovf} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               in_ready, out_valid, quotient, remainder, dbz, ovf);
    end
    RST = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned_basic();
    logic [15:0] q; logic [7:0] r; logic dz, of; int lat; bit to;
    run_op(16'd1000, 8'd7, q, r, dz, of, lat, to);
    checks++;
    if (to || {q, r, dz, of} !== {16'd142, 8'd6, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_1000_7: got q=%0d r=%0d dbz=%b ovf=%b to=%b, want q=142 r=6 dbz=0 ovf=0",
               q, r, dz, of, to);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL latency_1000_7: got %0d want %0d", lat, LAT);
    end
  endtask

  task automatic test_signed();
`ifdef DIV_SIGNED_EN
    logic [15:0] q; logic [7:0] r; logic dz, of; int lat; bit to;
    run_op(16'hFC18, 8'd7, q, r, dz, of, lat, to);
    checks++;
    if (to || {q, r, dz, of} !== {16'hFF72, 8'hFA, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_m1000_7: got q=%h r=%h dbz=%b ovf=%b, want q=ff72 r=fa", q, r, dz, of);
    end
    run_op(16'd1000, 8'hF9, q, r, dz, of, lat, to);
    checks++;
    if (to || {q, r, dz, of} !== {16'hFF72, 8'h06, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div_1000_m7: got q=%h r=%h dbz=%b ovf=%b, want q=ff72 r=06", q, r, dz, of);
    end
`endif
  endtask

  task automatic test_dbz();
    logic [15:0] q; logic [7:0] r; logic dz, of; int lat; bit to;
    run_op(16'h1234, 8'h00, q, r, dz, of, lat, to);
    checks++;
    if (to || {q, r, dz, of} !== {16'hFFFF, 8'h34, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dbz: got q=%h r=%h dbz=%b ovf=%b, want q=ffff r=34 dbz=1 ovf=0", q, r, dz, of);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL dbz_latency: got %0d want %0d", lat, LAT);
    end
  endtask

  task automatic test_ovf();
    logic [15:0] q, eq; logic [7:0] r, er; logic dz, of, ez, eo; int lat; bit to;
    run_op(16'h8000, 8'hFF, q, r, dz, of, lat, to);
`ifdef DIV_SIGNED_EN
    eq = 16'h8000; er = 8'h00; ez = 1'b0; eo = 1'b1;
`else
    eq = 16'd128;  er = 8'd128; ez = 1'b0; eo = 1'b0;
`endif
    checks++;
    if (to || {q, r, dz, of} !== {eq, er, ez, eo}) begin
      errors++;
      $display("FAIL ovf_case: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
               q, r, dz, of, eq, er, ez, eo);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a1, a2, eq; logic [7:0] b1, b2, er; logic ez, eo;
    logic [25:0] snap;
    int lat, n;
    a1 = 16'($urandom); b1 = 8'($urandom_range(255, 1));
    a2 = 16'($urandom); b2 = 8'($urandom_range(255, 1));
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    dividend = a1; divisor = b1; in_valid = 1'b1;
    @(negedge CLK);
    dividend = a2; divisor = b2;   // in_valid stays high while busy
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge CLK); lat++; end
    model(a1, b1, eq, er, ez, eo);
    checks++;
    if (lat != LAT || {quotient, remainder, dbz, ovf} !== {eq, er, ez, eo}) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h",
               lat, quotient, remainder, LAT, eq, er);
    end
    snap = {quotient, remainder, dbz, ovf};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if ({quotient, remainder, dbz, ovf} !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got out=%h vld=%b rdy=%b, want out=%h vld=1 rdy=0",
                 i, {quotient, remainder, dbz, ovf}, out_valid, in_ready, snap);
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: got rdy=%b want 0", in_ready);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin @(negedge CLK); lat++; end
    model(a2, b2, eq, er, ez, eo);
    checks++;
    if (lat != LAT || {quotient, remainder, dbz, ovf} !== {eq, er, ez, eo}) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h",
               lat, quotient, remainder, LAT, eq, er);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [15:0] q; logic [7:0] r; logic dz, of; int lat, n; bit to;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    dividend = 16'hBEEF; divisor = 8'h13; in_valid = 1'b1;
    @(negedge CLK);                 // cycle 1: LOAD
    in_valid = 1'b0;
    repeat (6) @(negedge CLK);      // cycle 7: CALC step 5
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, dbz, ovf} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               in_ready, out_valid, quotient, remainder, dbz, ovf);
    end
    run_op(16'd255, 8'd16, q, r, dz, of, lat, to);
    checks++;
    if (to || lat != LAT || {q, r, dz, of} !== {16'd15, 8'd15, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_fresh: got q=%0d r=%0d lat=%0d to=%b, want q=15 r=15 lat=%0d",
               q, r, lat, to, LAT);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, q, eq; logic [7:0] b, r, er; logic dz, of, ez, eo; int lat; bit to;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      case ($urandom_range(7, 0))
        0: b = 8'h00;
        1: b = 8'hFF;
        2: a = 16'h8000;
        3: begin a = 16'h8000; b = 8'hFF; end
        default: ;
      endcase
      run_op(a, b, q, r, dz, of, lat, to);
      model(a, b, eq, er, ez, eo);
      checks++;
      if (to || lat != LAT || {q, r, dz, of} !== {eq, er, ez, eo}) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h dbz=%b ovf=%b lat=%0d, want q=%h r=%h dbz=%b ovf=%b lat=%0d",
                 i, a, b, q, r, dz, of, lat, eq, er, ez, eo, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa[$]; logic [7:0] qb[$]; int acc[$];
    logic [15:0] a, eq; logic [7:0] b, er; logic ez, eo;
    int cyc, got; bit newop;
    cyc = 0; got = 0; newop = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (newop) begin dividend = 16'($urandom); divisor = 8'($urandom); newop = 1'b0; end
      if (out_valid === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_result: got q=%h with no pending op", quotient);
        end else begin
          a = qa.pop_front(); b = qb.pop_front();
          model(a, b, eq, er, ez, eo);
          if ({quotient, remainder, dbz, ovf} !== {eq, er, ez, eo}) begin
            errors++;
            $display("FAIL b2b_result %h/%h: got q=%h r=%h, want q=%h r=%h",
                     a, b, quotient, remainder, eq, er);
          end
        end
        got++;
      end
      if (in_ready === 1'b1) begin
        qa.push_back(dividend); qb.push_back(divisor); acc.push_back(cyc);
        newop = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got != 3 || acc.size() < 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results %0d accepts, want 3 and 3", got, acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] != 20) begin
          errors++;
          $display("FAIL b2b_interval[%0d]: got %0d want 20", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_dbz();
    test_ovf();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
